// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes, width default,
// output-register state encoding and the operand bundle handed to the ALU.
package alu_arbiter_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  // Output register state: one result slot, so EMPTY or FULL.
  typedef logic [0:0] out_state_t;
  localparam out_state_t ST_EMPTY = 1'b0;
  localparam out_state_t ST_FULL  = 1'b1;

  typedef struct packed {
    logic [3:0]            op;
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: AND, OR, ADD, SUB; any other op code passes operand A.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU behind a single result register.
// Define ALU_ARB_ROUND_ROBIN_EN for last-grant round robin; default is fixed priority to requester 0.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero
);

  out_state_t        state;
  logic              accept_ok;
  logic              grant1;
  logic              accept;
  alu_req_t          sel;
  logic [DATA_W-1:0] alu_y;

  // Free slot now, or the held result leaves this same cycle.
  assign accept_ok = !reset && ((state == ST_EMPTY) || rsp_ready);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_comb begin
    grant1 = 1'b0;
    if (req0_valid && req1_valid) grant1 = !last_grant;
    else                          grant1 = req1_valid;
  end

  always_ff @(posedge clk) begin
    if (reset)       last_grant <= 1'b1;
    else if (accept) last_grant <= grant1;
  end
`else
  assign grant1 = !req0_valid && req1_valid;
`endif

  assign req0_ready = accept_ok && req0_valid && !grant1;
  assign req1_ready = accept_ok && req1_valid &&  grant1;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    sel = grant1 ? '{op: req1_op, a: req1_a, b: req1_b}
                 : '{op: req0_op, a: req0_a, b: req0_b};
  end

  alu_arbiter_alu #(.DATA_W(DATA_W)) u_alu (
    .op (sel.op),
    .a  (sel.a),
    .b  (sel.b),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_EMPTY;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= 1'b0;
    end else if (accept) begin
      state      <= ST_FULL;
      rsp_result <= alu_y;
      rsp_zero   <= (alu_y == '0);
      rsp_id     <= grant1;
    end else if (state == ST_FULL && rsp_ready) begin
      state      <= ST_EMPTY;
    end
  end

  assign rsp_valid = (state == ST_FULL);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: req0_valid  in  1  requester 0 holds an operation.
REQ-005 Port: req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-006 Port: req0_a, req0_b  in  32 each  requester 0 operands.
REQ-007 Port: req0_op  in  4  requester 0 ALU control code.
REQ-008 Port: req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1.
REQ-009 Port: rsp_valid  out  1  result register holds a result.
REQ-010 Port: rsp_ready  in  1  consumer takes the result this cycle.
REQ-011 Port: rsp_id  out  1  requester that owns the result.
REQ-012 Port: rsp_result  out  32  registered ALU result.
REQ-013 Port: rsp_zero  out  1  high when rsp_result == 0.

Function
REQ-014 The block SHALL share one ALU instance between two requesters using valid/ready handshakes on both sides.
REQ-015 Operation codes SHALL be: 0000 AND, 0001 OR, 0010 ADD (mod 2^32), 0110 SUB (A-B mod 2^32), any other code passes A.
REQ-016 Output state SHALL be EMPTY (rsp_valid=0) or FULL (rsp_valid=1); there is one result register.
REQ-017 Accept is allowed when EMPTY, or when FULL with rsp_ready=1 in the same cycle (drain and refill).
REQ-018 At most one of req0_ready/req1_ready SHALL be high per cycle; readyN is high only when reqN_valid=1, accept is allowed and reqN wins arbitration.
REQ-019 Latency: an operation accepted in cycle N SHALL produce rsp_valid=1 with its result, zero flag and id in cycle N+1.
REQ-020 Throughput SHALL be one operation per cycle while rsp_ready stays high.
REQ-021 While FULL and rsp_ready=0, rsp_result, rsp_zero and rsp_id SHALL hold stable and both readys SHALL be 0.
REQ-022 FULL with rsp_ready=1 and no accept SHALL transition to EMPTY.
REQ-023 Arbitration SHALL use a last-grant pointer: if both valid, grant the requester not granted last; if one valid, grant it.
REQ-024 The pointer SHALL update only on an accepted operation.
REQ-025 Requesters SHALL hold valid and payload stable until accepted; the bench SHALL flag violations.
REQ-026 rsp_zero SHALL be computed by the arbiter from the result, not taken from the ALU zero output.

Reset
REQ-027 reset SHALL force EMPTY: rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_id=0, both readys 0.
REQ-028 reset SHALL set the last-grant pointer to 1, so requester 0 wins the first tie.
REQ-029 reset asserted while FULL SHALL discard the held result without a handshake.

Configuration
REQ-030 With macro ALU_ARB_ROUND_ROBIN_EN defined, arbitration SHALL follow REQ-023/024.
REQ-031 Without ALU_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win ties (fixed priority) and the pointer SHALL be omitted.

Structure
REQ-032 A shared package SHALL hold the 4-bit op-code constants (AND, OR, ADD, SUB), the DATA_W default and the EMPTY/FULL state type.
REQ-033 The existing ALU module SHALL be instantiated once as the sole sub-module; the arbiter and result register live in alu_arbiter.

Verification
REQ-034 Single op: req0 ADD a=5, b=7 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_result=12, rsp_zero=0, rsp_id=0.
REQ-035 SUB to zero: req1 op=0110 a=b=0x1234 -> rsp_result=0, rsp_zero=1, rsp_id=1. Wrap check: ADD 0xFFFFFFFF+1 -> result 0, zero=1.
REQ-036 Contention: both valid for 4 cycles, rsp_ready=1 -> with macro, grants alternate 0,1,0,1; without macro, grants are 0,0,0,0.
REQ-037 Backpressure: rsp_ready=0 for 3 cycles while FULL with OR 0xF0|0x0F -> rsp_result holds 0xFF, readys=0; rsp_ready=1 then drains it and a pending request is accepted in the same cycle.
REQ-038 Reset mid-operation: assert reset while FULL -> next cycle rsp_valid=0; the first tie after release grants requester 0.
REQ-039 Undefined op: op=1111 a=0xDEADBEEF -> rsp_result=0xDEADBEEF.
